// File: rtl/calc_exec_unit.sv
// -----------------------------------------------------------------------------
// calc_exec_unit
//
// Accumulator-based execution sequencer for the calculator. On `start` it runs
// the program held in a 16x8 instruction memory, operating on a 16x8 data
// memory, until HALT, an illegal opcode, or MAX_STEPS instructions have
// executed. Each instruction takes three cycles: FETCH, DECODE, EXECUTE.
//
// Parameters:
//   MAX_STEPS   instructions executed before forced termination (1..255)
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             begin execution at address 0 (sampled only in IDLE)
//   inst_addr/rdata   instruction memory read port (1-cycle read latency)
//   data_addr/rdata   data memory address and read data (1-cycle latency)
//   data_we/wdata     data memory write strobe (one cycle per ST) and data
//   busy              high while a program is running, including DONE
//   done              one-cycle pulse on termination
//   error             sticky illegal-opcode / step-limit flag
//   acc, zero, carry  accumulator and flags
//   pc                program counter
// -----------------------------------------------------------------------------
module calc_exec_unit #(
  parameter int unsigned MAX_STEPS = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] inst_addr,
  input  logic [7:0] inst_rdata,
  output logic [3:0] data_addr,
  input  logic [7:0] data_rdata,
  output logic       data_we,
  output logic [7:0] data_wdata,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] acc,
  output logic       zero,
  output logic       carry,
  output logic [3:0] pc
);

  localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LD   = 4'h1,
    OP_ST   = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_LDI  = 4'h8,
    OP_SHL  = 4'h9,
    OP_SHR  = 4'hA,
    OP_JMP  = 4'hB,
    OP_JZ   = 4'hC,
    OP_JC   = 4'hD,
    OP_ILL  = 4'hE,
    OP_HALT = 4'hF
  } op_e;

  state_e      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [7:0]  acc_q, acc_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic        error_q, error_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  step_q, step_d;
  logic [3:0]  daddr_q, daddr_d;

  op_e         op;
  logic [3:0]  field;
  logic [8:0]  sum;
  logic [8:0]  diff;

  assign op    = op_e'(ir_q[7:4]);
  assign field = ir_q[3:0];
  // Bit 8 of the 9-bit difference is the borrow out.
  assign sum   = {1'b0, acc_q} + {1'b0, data_rdata};
  assign diff  = {1'b0, acc_q} - {1'b0, data_rdata};

  // NOTE: every signal written below gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    error_d = error_q;
    ir_d    = ir_q;
    step_d  = step_q;
    daddr_d = daddr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          acc_d   = '0;
          zero_d  = 1'b0;
          carry_d = 1'b0;
          error_d = 1'b0;
          step_d  = '0;
        end
      end

      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        ir_d    = inst_rdata;
        daddr_d = inst_rdata[3:0];
        state_d = S_EXECUTE;
      end

      S_EXECUTE: begin
        step_d  = step_q + 8'd1;
        pc_d    = pc_q + 4'd1;
        state_d = S_FETCH;

        unique case (op)
          OP_LD:   acc_d = data_rdata;
          OP_ADD:  {carry_d, acc_d} = sum;
          OP_SUB:  {carry_d, acc_d} = diff;
          OP_AND:  acc_d = acc_q & data_rdata;
          OP_OR:   acc_d = acc_q | data_rdata;
          OP_XOR:  acc_d = acc_q ^ data_rdata;
          OP_LDI:  acc_d = {4'h0, field};
          OP_SHL:  {carry_d, acc_d} = {acc_q, 1'b0};
          OP_SHR:  {acc_d, carry_d} = {1'b0, acc_q};
          OP_JMP:  pc_d = field;
          OP_JZ:   if (zero_q)  pc_d = field;
          OP_JC:   if (carry_q) pc_d = field;
          OP_ILL: begin
            pc_d    = pc_q;
            error_d = 1'b1;
            state_d = S_DONE;
          end
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_DONE;
          end
          default: ; // NOP and ST change no registers here
        endcase

        if (op == OP_LD || (op >= OP_ADD && op <= OP_SHR)) begin
          zero_d = (acc_d == 8'h00);
        end

        // The instruction that hits the limit still completes; only a HALT
        // landing exactly on the limit counts as a clean finish.
        if (step_d == STEP_LIMIT) begin
          state_d = S_DONE;
          if (op != OP_HALT) error_d = 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its _d input regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      error_q <= 1'b0;
      ir_q    <= '0;
      step_q  <= '0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      error_q <= error_d;
      ir_q    <= ir_d;
      step_q  <= step_d;
      daddr_q <= daddr_d;
    end
  end

  // The data address must reach memory during DECODE so operand data is ready
  // in EXECUTE; it is then held for EXECUTE (ST) and beyond.
  assign data_addr  = (state_q == S_DECODE) ? inst_rdata[3:0] : daddr_q;
  assign inst_addr  = pc_q;
  // NOTE: the write strobe is masked by rst combinationally so a reset landing
  // on a ST EXECUTE cycle suppresses the memory write at that same edge.
  assign data_we    = (state_q == S_EXECUTE) && (op == OP_ST) && !rst;
  assign data_wdata = acc_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign error      = error_q;
  assign acc        = acc_q;
  assign zero       = zero_q;
  assign carry      = carry_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_calc_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_calc_exec_unit
//
// Self-checking bench for calc_exec_unit. Two instances share the instruction
// and data memories: one with the default step limit and one with MAX_STEPS=8.
// An instruction-level model predicts the architectural state after each
// instruction; the run task compares the selected instance against it at every
// instruction boundary and checks done/busy every cycle. Literal expectations
// after each program pin the model itself.
// -----------------------------------------------------------------------------
module tb_calc_exec_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;   // 0: default instance, 1: MAX_STEPS=8 instance

  always #5 clk = ~clk;

  logic [3:0] inst_addr_a, inst_addr_b, data_addr_a, data_addr_b;
  logic [7:0] inst_rdata_a, inst_rdata_b, data_rdata_a, data_rdata_b;
  logic [7:0] data_wdata_a, data_wdata_b, acc_a, acc_b;
  logic [3:0] pc_a, pc_b;
  logic data_we_a, data_we_b, busy_a, busy_b, done_a, done_b;
  logic error_a, error_b, zero_a, zero_b, carry_a, carry_b;

  calc_exec_unit u_dut (
    .clk(clk), .rst(rst), .start(start & ~sel),
    .inst_addr(inst_addr_a), .inst_rdata(inst_rdata_a),
    .data_addr(data_addr_a), .data_rdata(data_rdata_a),
    .data_we(data_we_a), .data_wdata(data_wdata_a),
    .busy(busy_a), .done(done_a), .error(error_a),
    .acc(acc_a), .zero(zero_a), .carry(carry_a), .pc(pc_a)
  );

  calc_exec_unit #(.MAX_STEPS(8)) u_dut_lim (
    .clk(clk), .rst(rst), .start(start & sel),
    .inst_addr(inst_addr_b), .inst_rdata(inst_rdata_b),
    .data_addr(data_addr_b), .data_rdata(data_rdata_b),
    .data_we(data_we_b), .data_wdata(data_wdata_b),
    .busy(busy_b), .done(done_b), .error(error_b),
    .acc(acc_b), .zero(zero_b), .carry(carry_b), .pc(pc_b)
  );

  // Selected-instance views
  wire [7:0] acc_w     = sel ? acc_b     : acc_a;
  wire [3:0] pc_w      = sel ? pc_b      : pc_a;
  wire       zero_w    = sel ? zero_b    : zero_a;
  wire       carry_w   = sel ? carry_b   : carry_a;
  wire       error_w   = sel ? error_b   : error_a;
  wire       busy_w    = sel ? busy_b    : busy_a;
  wire       done_w    = sel ? done_b    : done_a;
  wire       data_we_w = sel ? data_we_b : data_we_a;
  wire [3:0] iaddr_w   = sel ? inst_addr_b : inst_addr_a;
  wire [3:0] daddr_w   = sel ? data_addr_b : data_addr_a;
  wire [7:0] wdata_w   = sel ? data_wdata_b : data_wdata_a;

  // Synchronous memories, one-cycle read latency, read-before-write
  logic [7:0] imem [16];
  logic [7:0] dmem [16];

  always @(posedge clk) begin
    inst_rdata_a = imem[inst_addr_a];
    inst_rdata_b = imem[inst_addr_b];
    data_rdata_a = dmem[data_addr_a];
    data_rdata_b = dmem[data_addr_b];
    if (data_we_a) dmem[data_addr_a] = data_wdata_a;
    if (data_we_b) dmem[data_addr_b] = data_wdata_b;
  end

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Instruction-level model: architectural state after each instruction
  // ---------------------------------------------------------------------------
  int         t_acc [256];
  int         t_pc  [256];
  int         t_z   [256];
  int         t_c   [256];
  int         t_err [256];
  int         m_n;
  int         m_st;
  logic [7:0] m_dmem [16];

  function automatic void model_run(input int max_steps);
    int a, p, np, z, c, err, op, f, m, r;
    bit stop;
    a = 0; p = 0; z = 0; c = 0; err = 0; stop = 0;
    m_n = 0; m_st = 0;
    m_dmem = dmem;
    while (!stop) begin
      op = int'(imem[p][7:4]);
      f  = int'(imem[p][3:0]);
      m  = int'(m_dmem[f]);
      np = (p + 1) % 16;
      case (op)
        1:  a = m;
        2:  begin m_dmem[f] = 8'(a); m_st++; end
        3:  begin r = a + m; c = (r > 255) ? 1 : 0; a = r % 256; end
        4:  begin c = (a < m) ? 1 : 0; a = (a - m + 256) % 256; end
        5:  a = a & m;
        6:  a = a | m;
        7:  a = a ^ m;
        8:  a = f;
        9:  begin c = (a >= 128) ? 1 : 0; a = (a * 2) % 256; end
        10: begin c = a % 2; a = a / 2; end
        11: np = f;
        12: if (z == 1) np = f;
        13: if (c == 1) np = f;
        14: begin err = 1; stop = 1; np = p; end
        15: begin stop = 1; np = p; end
        default: ;
      endcase
      if (op == 1 || (op >= 3 && op <= 10)) z = (a == 0) ? 1 : 0;
      m_n++;
      if (m_n == max_steps) begin
        stop = 1;
        if (op != 15) err = 1;
      end
      t_acc[m_n-1] = a; t_pc[m_n-1] = np; t_z[m_n-1] = z;
      t_c[m_n-1] = c;   t_err[m_n-1] = err;
      p = np;
    end
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      imem[i] = 8'hF0;
      dmem[i] = 8'h00;
    end
  endtask

  // Runs the loaded program on the selected instance and compares every cycle.
  // `inj` > 0 pulses start during the run at that cycle to show it is ignored.
  task automatic run(input string tag, input bit use_lim, input int inj);
    int we_seen, k, last, bad;
    sel = use_lim;
    model_run(use_lim ? 8 : 255);
    last = 3 * m_n;
    we_seen = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;      // edge 0: start accepted
    for (int e = 1; e <= last + 1; e++) begin
      @(posedge clk); #1;
      start = (e == inj);
      if (data_we_w === 1'b1) we_seen++;
      if (e == 1) check({tag, " err_clr"}, error_w, 0);
      check($sformatf("%s done@%0d", tag, e), done_w, (e == last) ? 1 : 0);
      check($sformatf("%s busy@%0d", tag, e), busy_w, (e <= last) ? 1 : 0);
      if (e % 3 == 0 && e <= last) begin
        k = e / 3 - 1;
        check($sformatf("%s acc[%0d]", tag, k),   acc_w,   t_acc[k]);
        check($sformatf("%s zero[%0d]", tag, k),  zero_w,  t_z[k]);
        check($sformatf("%s carry[%0d]", tag, k), carry_w, t_c[k]);
        check($sformatf("%s pc[%0d]", tag, k),    pc_w,    t_pc[k]);
        check($sformatf("%s err[%0d]", tag, k),   error_w, t_err[k]);
      end
    end
    start = 1'b0;
    check({tag, " we_cycles"}, we_seen, m_st);
    bad = 0;
    for (int i = 0; i < 16; i++) if (dmem[i] !== m_dmem[i]) bad++;
    check({tag, " dmem_mismatches"}, bad, 0);
  endtask

  task automatic lit(input string tag, input int n, input int a, input int z,
                     input int c, input int err, input int p);
    check({tag, " lit_steps"}, m_n, n);
    check({tag, " lit_acc"},   acc_w, a);
    check({tag, " lit_zero"},  zero_w, z);
    check({tag, " lit_carry"}, carry_w, c);
    check({tag, " lit_err"},   error_w, err);
    check({tag, " lit_pc"},    pc_w, p);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " busy"}, busy_w, 0);   check({tag, " done"}, done_w, 0);
    check({tag, " error"}, error_w, 0); check({tag, " acc"}, acc_w, 0);
    check({tag, " zero"}, zero_w, 0);   check({tag, " carry"}, carry_w, 0);
    check({tag, " pc"}, pc_w, 0);       check({tag, " we"}, data_we_w, 0);
    check({tag, " iaddr"}, iaddr_w, 0); check({tag, " daddr"}, daddr_w, 0);
    check({tag, " wdata"}, wdata_w, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; check_reset("reset_a");
    sel = 1'b1; check_reset("reset_b");
    rst = 1'b0;

    // Illegal opcode at address 0: terminates after one instruction
    clear_mem(); imem[0] = 8'hE3;
    run("illegal", 1'b0, 0);
    lit("illegal", 1, 8'h00, 0, 0, 1, 0);

    // Load/add/store (also clears the previous error on start)
    clear_mem();
    imem[0] = 8'h10; imem[1] = 8'h31; imem[2] = 8'h22; imem[3] = 8'hF0;
    dmem[0] = 8'hAA; dmem[1] = 8'h55;
    run("las", 1'b0, 0);
    lit("las", 4, 8'hFF, 0, 0, 0, 3);
    check("las dmem2", dmem[2], 8'hFF);
    check("las we_lit", m_st, 1);

    // 0xF0 + 0x20: LDI F, SHL x4, ADD M[1]
    clear_mem();
    imem[0] = 8'h8F; imem[1] = 8'h90; imem[2] = 8'h90; imem[3] = 8'h90;
    imem[4] = 8'h90; imem[5] = 8'h31; dmem[1] = 8'h20;
    run("add_c", 1'b0, 0);
    lit("add_c", 7, 8'h10, 0, 1, 0, 6);

    // 0x05 - 0x05
    clear_mem();
    imem[0] = 8'h85; imem[1] = 8'h20; imem[2] = 8'h40;
    run("sub_z", 1'b0, 0);
    lit("sub_z", 4, 8'h00, 1, 0, 0, 3);

    // 0x03 - 0x05
    clear_mem();
    imem[0] = 8'h85; imem[1] = 8'h20; imem[2] = 8'h83; imem[3] = 8'h40;
    run("sub_b", 1'b0, 0);
    lit("sub_b", 5, 8'hFE, 0, 1, 0, 4);

    // SHL on 0x81
    clear_mem();
    imem[0] = 8'h13; imem[1] = 8'h90; dmem[3] = 8'h81;
    run("shl", 1'b0, 0);
    lit("shl", 3, 8'h02, 0, 1, 0, 2);

    // Countdown loop from 3, with a stray start pulse while busy
    clear_mem();
    imem[0] = 8'h83; imem[1] = 8'h41; imem[2] = 8'hC4; imem[3] = 8'hB1;
    dmem[1] = 8'h01;
    run("loop", 1'b0, 7);
    lit("loop", 10, 8'h00, 1, 0, 0, 4);

    // JC not taken with C=0
    clear_mem();
    imem[0] = 8'h81; imem[1] = 8'hD3; imem[2] = 8'h82;
    run("jc_nt", 1'b0, 0);
    lit("jc_nt", 4, 8'h02, 0, 0, 0, 3);

    // pc wrap 15 -> 0
    clear_mem();
    imem[0] = 8'hC5; imem[1] = 8'hBF; imem[15] = 8'h10; imem[5] = 8'hF0;
    run("wrap", 1'b0, 0);
    lit("wrap", 5, 8'h00, 1, 0, 0, 5);

    // Step limit: JMP 0 forever on the MAX_STEPS=8 instance
    clear_mem(); imem[0] = 8'hB0;
    run("limit", 1'b1, 0);
    lit("limit", 8, 8'h00, 0, 0, 1, 0);

    // rst and start together: rst wins
    sel = 1'b0;
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1; rst = 1'b0; start = 1'b0;
    check("race busy0", busy_w, 0);
    @(posedge clk); #1;
    check("race busy1", busy_w, 0);

    // rst during the EXECUTE cycle of a ST: no write, outputs back to reset
    clear_mem();
    imem[0] = 8'h87; imem[1] = 8'h25; dmem[5] = 8'h33;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;      // edge 0
    repeat (5) @(posedge clk);             // edge 5: ST enters EXECUTE
    #1;
    check("st_rst we_pre", data_we_w, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("st_rst dmem5", dmem[5], 8'h33);
    check_reset("st_rst");
    @(posedge clk); #1;
    check("st_rst dmem5_late", dmem[5], 8'h33);
    check("st_rst idle", busy_w, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_exec_unit.md
# calc_exec_unit

Accumulator-based execution sequencer that sits directly downstream of the calculator's 16x8 instruction and data memories. On `start` it fetches 8-bit instructions from instruction memory and reads or writes operands in data memory. It executes ALU, load/store and branch operations until HALT, an illegal opcode or a step limit. The result stays in the accumulator and in data memory.

## Interface
- `MAX_STEPS`, 255: instructions executed before forced termination with error; legal range 1–255.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin execution at address 0; sampled only in IDLE.
- `inst_addr`  out  4  instruction memory read address.
- `inst_rdata`  in  8  instruction memory read data, valid one cycle after `inst_addr`.
- `data_addr`  out  4  data memory address, shared by read and write.
- `data_rdata`  in  8  data memory read data, valid one cycle after `data_addr`.
- `data_we`  out  1  data memory write enable, one cycle per STORE.
- `data_wdata`  out  8  data memory write data (accumulator).
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is left.
- `done`  out  1  one-cycle pulse on termination.
- `error`  out  1  sticky; set on illegal opcode or step-limit expiry; cleared by the next accepted `start` or by `rst`.
- `acc`  out  8  accumulator.
- `zero`, `carry`  out  1 each  flags.
- `pc`  out  4  program counter.

## Operation
- Instruction format: [7:4] opcode, [3:0] operand field `f`, which is either a data address or an immediate.
- Opcodes:
  - 0 NOP
  - 1 LD: acc←M[f]
  - 2 ST: M[f]←acc
  - 3 ADD: {C,acc}←acc+M[f]
  - 4 SUB: acc←acc−M[f], C=borrow
  - 5 AND, 6 OR, 7 XOR with M[f]
  - 8 LDI: acc←{4'h0,f}
  - 9 SHL: C←acc[7], acc←acc<<1
  - A SHR: C←acc[0], acc←acc>>1
  - B JMP: pc←f
  - C JZ: pc←f if Z
  - D JC: pc←f if C
  - E illegal
  - F HALT
- Flag update rules:
  - Z is updated by opcodes 1, 3–A: Z=(new acc==0).
  - C is updated only by 3, 4, 9, A.
  - All other opcodes leave both flags unchanged.
- All arithmetic is 8-bit modulo 256. C is the 9th bit of the sum, or the borrow of the subtraction.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, DONE.
  - IDLE → FETCH when `start`=1. Accepting `start` clears pc, acc, Z, C, error and the step counter.
  - FETCH: drive `inst_addr`=pc. Next state is DECODE.
  - DECODE: latch IR←`inst_rdata`, drive `data_addr`=`inst_rdata`[3:0]. Next state is EXECUTE.
  - EXECUTE: consume `data_rdata`, update acc/flags/pc, and increment the step counter.
    - Next state is FETCH, or DONE on HALT, opcode E, or the step counter reaching MAX_STEPS.
  - DONE: `done`=1 for this cycle. Next state is IDLE.
- Sequential pc is pc+1 mod 16, so 15 wraps to 0. Taken branches load f.
- ST asserts `data_we` in EXECUTE only, with `data_addr`=f and `data_wdata`=acc.
- HALT leaves pc pointing at the HALT instruction.
- Opcode E sets `error`, changes no other state, and terminates.
- Step-limit expiry:
  - The instruction in EXECUTE completes normally.
  - `error` is set unless that instruction is HALT.
  - Termination follows.
- `start` while busy is ignored.

## Timing
- Every instruction takes exactly 3 cycles (FETCH, DECODE, EXECUTE). There is no pipelining or overlap.
- If `start` is sampled at edge 0, instruction k enters EXECUTE at edge 3k+2. DONE follows at the next edge.
- Register updates from EXECUTE (acc, flags, pc, error) are visible in the cycle after EXECUTE.
- Reset values:
  - state=IDLE, pc=0, acc=0, zero=0, carry=0, error=0, busy=0, done=0, data_we=0, inst_addr=0, data_addr=0, data_wdata=0.
- `rst` mid-instruction, including during a ST EXECUTE: the state returns to IDLE at that edge and `data_we` is 0 in the following cycle.
- `rst` and `start` in the same cycle: `rst` wins and `start` is ignored.
- `data_addr` is undefined-but-stable outside DECODE/EXECUTE and is held at its last value.

## Test plan
- Load/add/store: imem {0x10,0x31,0x22,0xF0}, dmem[0]=0xAA, dmem[1]=0x55, start.
  - Expected: dmem[2]=0xFF, acc=0xFF, Z=0, C=0, error=0, pc=3.
  - `done` pulses once, 12 edges after the start edge.
  - `data_we` is high for exactly one cycle.
- Carry/zero: LDI-based sequences.
  - 0xF0+0x20 → acc=0x10, C=1.
  - 0x05−0x05 → acc=0x00, Z=1, C=0.
  - 0x03−0x05 → acc=0xFE, C=1.
  - SHL on 0x81 → acc=0x02, C=1.
- Branches:
  - Countdown loop using SUB and JZ exits with acc=0 after the expected instruction count.
  - JC not taken when C=0.
  - Sequential execution from pc=15 wraps to 0.
- Termination errors:
  - Opcode 0xE3 at address 0 → `error`=1 and `done` after 3 cycles; acc unchanged.
  - With MAX_STEPS=8 and imem[0]=0xB0 (JMP 0) → `done` after exactly 8 instructions, `error`=1.
- Reset/start races:
  - `rst` asserted in the EXECUTE cycle of a ST → no write occurs, all outputs return to reset values.
  - `start` pulsed while busy → no effect.
  - A new `start` after an error clears `error`.
